// File: rtl/coin_credit_fsm.sv
// Coin credit controller: accumulates coins, vends products A/B, and refunds on cancel.
// Optional idle auto-refund is enabled by defining COIN_TIMEOUT_EN.
module coin_credit_fsm #(
    parameter int PRICE_A        = 2,
    parameter int PRICE_B        = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin1,
    input  logic       coin2,
    input  logic       coin5,
    input  logic       selA,
    input  logic       selB,
    input  logic       cancel,
    output logic [3:0] total,
    output logic       vendA,
    output logic       vendB,
    output logic       refund,
    output logic       coin_reject,
    output logic       insufficient
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] VEND   = 2'd2;
    localparam logic [1:0] REFUND = 2'd3;

    localparam logic [4:0] PA = 5'(PRICE_A);
    localparam logic [4:0] PB = 5'(PRICE_B);

    logic [1:0] state, state_nx;
    logic [3:0] credit, credit_nx;
    logic       vend_a_nx, vend_b_nx, refund_nx, reject_nx, insuf_nx;
    logic [4:0] coin_val;
    logic [4:0] sum;
    logic       any_coin, multi_coin, coin_fits;
    logic       timeout_hit;

    assign any_coin   = coin1 | coin2 | coin5;
    assign multi_coin = (coin1 & coin2) | (coin1 & coin5) | (coin2 & coin5);

    always_comb begin
        coin_val = '0;
        if (coin1)      coin_val = 5'd1;
        else if (coin2) coin_val = 5'd2;
        else if (coin5) coin_val = 5'd5;
    end

    // Sum is one bit wider than credit so overflow is detected instead of wrapping.
    assign sum       = {1'b0, credit} + coin_val;
    assign coin_fits = (sum <= 5'd15);

`ifdef COIN_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] idle_cnt;
    logic          in_pulse;

    assign in_pulse    = any_coin | selA | selB | cancel;
    assign timeout_hit = (state == ACCUM) && !in_pulse &&
                         (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         idle_cnt <= '0;
        else if (state != ACCUM || in_pulse)  idle_cnt <= '0;
        else if (!timeout_hit)                idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        credit_nx = credit;
        vend_a_nx = 1'b0;
        vend_b_nx = 1'b0;
        refund_nx = 1'b0;
        reject_nx = 1'b0;
        insuf_nx  = 1'b0;
        case (state)
            VEND, REFUND: begin
                state_nx  = IDLE;
                credit_nx = '0;
                reject_nx = any_coin;
            end
            default: begin
                // Priority: cancel, then selects, then coins; a coin losing priority is rejected.
                if (cancel) begin
                    reject_nx = any_coin;
                    if (state == ACCUM) begin
                        state_nx  = REFUND;
                        refund_nx = 1'b1;
                    end
                end else if (selA || selB) begin
                    reject_nx = any_coin;
                    if (selA && !selB) begin
                        if (state == ACCUM && {1'b0, credit} >= PA) begin
                            state_nx  = VEND;
                            vend_a_nx = 1'b1;
                        end else begin
                            insuf_nx = 1'b1;
                        end
                    end else if (selB && !selA) begin
                        if (state == ACCUM && {1'b0, credit} >= PB) begin
                            state_nx  = VEND;
                            vend_b_nx = 1'b1;
                        end else begin
                            insuf_nx = 1'b1;
                        end
                    end
                end else if (any_coin) begin
                    if (!multi_coin && coin_fits) begin
                        credit_nx = sum[3:0];
                        state_nx  = ACCUM;
                    end else begin
                        reject_nx = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_nx  = REFUND;
                    refund_nx = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            credit       <= '0;
            vendA        <= 1'b0;
            vendB        <= 1'b0;
            refund       <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            state        <= state_nx;
            credit       <= credit_nx;
            vendA        <= vend_a_nx;
            vendB        <= vend_b_nx;
            refund       <= refund_nx;
            coin_reject  <= reject_nx;
            insufficient <= insuf_nx;
        end
    end

    assign total = credit;

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Directed scoreboard bench for coin_credit_fsm; expectation vector is
// {total[3:0], vendA, vendB, refund, coin_reject, insufficient}.
module tb_coin_credit_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       coin1 = 1'b0, coin2 = 1'b0, coin5 = 1'b0;
    logic       selA = 1'b0, selB = 1'b0, cancel = 1'b0;
    logic [3:0] total;
    logic       vendA, vendB, refund, coin_reject, insufficient;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    // Input vectors: {cancel, selB, selA, coin5, coin2, coin1}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] C1   = 6'b000001;
    localparam logic [5:0] C2   = 6'b000010;
    localparam logic [5:0] C5   = 6'b000100;
    localparam logic [5:0] SA   = 6'b001000;
    localparam logic [5:0] SB   = 6'b010000;
    localparam logic [5:0] CN   = 6'b100000;

    // Pulse fields: {vendA, vendB, refund, coin_reject, insufficient}
    localparam logic [4:0] P0  = 5'b00000;
    localparam logic [4:0] VA  = 5'b10000;
    localparam logic [4:0] VB  = 5'b01000;
    localparam logic [4:0] RF  = 5'b00100;
    localparam logic [4:0] RJ  = 5'b00010;
    localparam logic [4:0] INS = 5'b00001;

    coin_credit_fsm #(
        .PRICE_A(2),
        .PRICE_B(3),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .coin1(coin1),
        .coin2(coin2),
        .coin5(coin5),
        .selA(selA),
        .selB(selB),
        .cancel(cancel),
        .total(total),
        .vendA(vendA),
        .vendB(vendB),
        .refund(refund),
        .coin_reject(coin_reject),
        .insufficient(insufficient)
    );

    always #5 clk = ~clk;

    task automatic check();
        logic [8:0] e, obs;
        string      t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {total, vendA, vendB, refund, coin_reject, insufficient};
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
    endtask

    task automatic expect_now(input string t, input logic [3:0] tot, input logic [4:0] p);
        exp_q.push_back({tot, p});
        tag_q.push_back(t);
        check();
    endtask

    task automatic step(input string t, input logic [5:0] in, input logic [3:0] tot, input logic [4:0] p);
        @(negedge clk);
        {cancel, selB, selA, coin5, coin2, coin1} = in;
        exp_q.push_back({tot, p});
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        {cancel, selB, selA, coin5, coin2, coin1} = NONE;
        check();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset", 4'd0, P0);
        @(negedge clk);
        reset_n = 1'b1;

        // Accumulate then vend B
        step("c1",        C1,   4'd1, P0);
        step("c2",        C2,   4'd3, P0);
        step("vendB",     SB,   4'd3, VB);
        step("vendB_clr", NONE, 4'd0, P0);

        // Saturation at 15
        step("c5a",       C5,   4'd5,  P0);
        step("c5b",       C5,   4'd10, P0);
        step("c5c",       C5,   4'd15, P0);
        step("sat_rej",   C1,   4'd15, RJ);
        step("cancel15",  CN,   4'd15, RF);
        step("cancel_clr",NONE, 4'd0,  P0);

        // Insufficient credit paths
        step("c1_ins",    C1,   4'd1, P0);
        step("insB",      SB,   4'd1, INS);
        step("insA",      SA,   4'd1, INS);
        step("c1_more",   C1,   4'd2, P0);
        step("vendA",     SA,   4'd2, VA);
        step("vendA_clr", NONE, 4'd0, P0);

        // Cancel beats select
        step("c5_cn",     C5,      4'd5, P0);
        step("cn_selA",   CN | SA, 4'd5, RF);
        step("cn_clr",    NONE,    4'd0, P0);

        // Multi-coin, IDLE select/cancel
        step("multi",     C1 | C2, 4'd0, RJ);
        step("idle_sel",  SA,      4'd0, INS);
        step("idle_cn",   CN,      4'd0, P0);

        // Both selects ignored, coin during VEND rejected
        step("c2_ab",     C2,      4'd2, P0);
        step("selAB",     SA | SB, 4'd2, P0);
        step("vendA2",    SA,      4'd2, VA);
        step("vend_coin", C1,      4'd0, RJ);

        // Select beats coin; cancel beats coin
        step("c2_sc",     C2,      4'd2, P0);
        step("sel_coin",  SA | C1, 4'd2, VA | RJ);
        step("sc_clr",    NONE,    4'd0, P0);
        step("c1_cc",     C1,      4'd1, P0);
        step("cn_coin",   CN | C5, 4'd1, RF | RJ);
        step("cc_clr",    NONE,    4'd0, P0);

        // 14 + 2 overflows, 14 + 1 fits exactly
        step("s5a",       C5,   4'd5,  P0);
        step("s5b",       C5,   4'd10, P0);
        step("s2a",       C2,   4'd12, P0);
        step("s2b",       C2,   4'd14, P0);
        step("s2_rej",    C2,   4'd14, RJ);
        step("s1_fit",    C1,   4'd15, P0);
        step("s_cn",      CN,   4'd15, RF);
        step("s_clr",     NONE, 4'd0,  P0);

`ifdef COIN_TIMEOUT_EN
        step("to_c2",     C2,   4'd2, P0);
        step("to_i1",     NONE, 4'd2, P0);
        step("to_i2",     NONE, 4'd2, P0);
        step("to_restart",C1,   4'd3, P0);
        step("to_r1",     NONE, 4'd3, P0);
        step("to_r2",     NONE, 4'd3, P0);
        step("to_r3",     NONE, 4'd3, P0);
        step("to_refund", NONE, 4'd3, RF);
        step("to_clr",    NONE, 4'd0, P0);
        step("to2_c2",    C2,   4'd2, P0);
        repeat (3) step("to2_idle", NONE, 4'd2, P0);
        step("to2_refund",NONE, 4'd2, RF);
        step("to2_clr",   NONE, 4'd0, P0);
`else
        step("hold_c2",   C2,   4'd2, P0);
        repeat (20) step("hold_idle", NONE, 4'd2, P0);
        step("hold_cn",   CN,   4'd2, RF);
        step("hold_clr",  NONE, 4'd0, P0);
`endif

        // Reset asserted during the vendA cycle
        step("rv_c1a",    C1,   4'd1, P0);
        step("rv_c1b",    C1,   4'd2, P0);
        step("rv_vendA",  SA,   4'd2, VA);
        #2;
        reset_n = 1'b0;
        #1;
        expect_now("rst_abort", 4'd0, P0);
        coin5 = 1'b1;
        @(posedge clk);
        #1;
        expect_now("rst_hold", 4'd0, P0);
        @(negedge clk);
        coin5   = 1'b0;
        reset_n = 1'b1;
        step("post_rst",  C1,   4'd1, P0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
